// File: rtl/rx78_pkg.sv
// RX-78 cart loader shared types.
// Address map boundaries, FSM states and cart size codes.
package rx78_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_HOLD
    } state_t;

    typedef enum logic [1:0] {
        D_C1,
        D_C2,
        D_EXT,
        D_DROP
    } dest_t;

    typedef enum logic [1:0] {
        CS_NONE = 2'd0,
        CS_8K   = 2'd1,
        CS_16K  = 2'd2,
        CS_BIG  = 2'd3
    } cart_size_t;

    localparam logic [16:0] CART1_END = 17'h2000;
    localparam logic [16:0] CART2_END = 17'h4000;
    localparam logic [16:0] EXT_BASE  = 17'h4000;

endpackage

// File: rtl/rx78_cart_loader.sv
// RX-78 cartridge upload stage: routes host bytes to cart/ext RAM,
// clears VRAM, and keeps the Z80 in reset until the image is complete.
module rx78_cart_loader #(
    parameter logic [7:0]  CART_INDEX  = 8'd1,
    parameter logic [16:0] MAX_BYTES   = 17'h9000,
    parameter logic [13:0] VRAM_WORDS  = 14'd8192,
    parameter int          HOLD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        upload,
    input  logic [7:0]  upload_index,
    input  logic [24:0] upload_addr,
    input  logic [7:0]  upload_data,
    input  logic        upload_wr,
    output logic        c1_we,
    output logic        c2_we,
    output logic [12:0] c_addr,
    output logic [7:0]  c_data,
    output logic        ext_we,
    output logic [14:0] ext_addr,
    output logic [7:0]  ext_data,
    output logic        vclr_we,
    output logic [12:0] vclr_addr,
    output logic        cpu_hold,
    output logic        busy,
    output logic [1:0]  cart_size,
    output logic        overflow
);
    import rx78_pkg::*;

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [13:0] VRAM_LAST = VRAM_WORDS - 14'd1;

    state_t        state;
    dest_t         dest;
    logic [16:0]   max_q;
    logic [16:0]   max_nxt;
    logic [16:0]   a_end;
    logic [13:0]   vcnt;
    logic [HW-1:0] hcnt;

    function automatic dest_t decode(input logic [24:0] a);
        logic [16:0] lo;
        logic        hi;
        dest_t       d;
        lo = a[16:0];
        hi = |a[24:17];
        d  = D_DROP;
        unique case (1'b1)
            !hi && lo < CART1_END:
                d = D_C1;
            !hi && lo >= CART1_END && lo < CART2_END:
                d = D_C2;
            !hi && lo >= EXT_BASE && lo < MAX_BYTES:
                d = D_EXT;
            hi || lo >= MAX_BYTES:
                d = D_DROP;
            default:
                d = D_DROP;
        endcase
        return d;
    endfunction

    function automatic cart_size_t size_of(input logic [16:0] m);
        cart_size_t s;
        s = CS_NONE;
        unique case (1'b1)
            m == 17'd0:
                s = CS_NONE;
            m != 17'd0 && m <= CART1_END:
                s = CS_8K;
            m > CART1_END && m <= CART2_END:
                s = CS_16K;
            m > CART2_END:
                s = CS_BIG;
            default:
                s = CS_NONE;
        endcase
        return s;
    endfunction

    // Highest accepted address + 1; includes the byte of this cycle so
    // a strobe coincident with the upload falling edge sizes correctly.
    always_comb begin
        dest    = decode(upload_addr);
        a_end   = upload_addr[16:0] + 17'd1;
        max_nxt = max_q;
        if (state == S_LOAD && upload_wr &&
            dest != D_DROP && a_end > max_q) begin
            max_nxt = a_end;
        end
    end

    assign vclr_addr = vcnt[12:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            c1_we     <= 1'b0;
            c2_we     <= 1'b0;
            c_addr    <= '0;
            c_data    <= '0;
            ext_we    <= 1'b0;
            ext_addr  <= '0;
            ext_data  <= '0;
            vclr_we   <= 1'b0;
            cpu_hold  <= 1'b0;
            busy      <= 1'b0;
            cart_size <= CS_NONE;
            overflow  <= 1'b0;
            max_q     <= '0;
            vcnt      <= '0;
            hcnt      <= '0;
        end else begin
            c1_we  <= 1'b0;
            c2_we  <= 1'b0;
            ext_we <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (upload && upload_index == CART_INDEX) begin
                        state    <= S_LOAD;
                        cpu_hold <= 1'b1;
                        busy     <= 1'b1;
                        max_q    <= '0;
                        overflow <= 1'b0;
                    end
                end
                S_LOAD: begin
                    max_q <= max_nxt;
                    if (upload_wr) begin
                        unique case (dest)
                            D_C1, D_C2: begin
                                c1_we  <= dest == D_C1;
                                c2_we  <= dest == D_C2;
                                c_addr <= upload_addr[12:0];
                                c_data <= upload_data;
                            end
                            D_EXT: begin
                                ext_we   <= 1'b1;
                                ext_addr <= upload_addr[14:0]
                                          - EXT_BASE[14:0];
                                ext_data <= upload_data;
                            end
                            default: overflow <= 1'b1;
                        endcase
                    end
                    if (!upload) begin
                        state     <= S_CLEAR;
                        cart_size <= size_of(max_nxt);
                        vcnt      <= '0;
                        vclr_we   <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (vcnt == VRAM_LAST) begin
                        state   <= S_HOLD;
                        vclr_we <= 1'b0;
                        hcnt    <= '0;
                    end else begin
                        vcnt <= vcnt + 14'd1;
                    end
                end
                S_HOLD: begin
                    if (hcnt == HOLD_LAST) begin
                        state    <= S_IDLE;
                        cpu_hold <= 1'b0;
                        busy     <= 1'b0;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/rx78_cart_loader.md
Name: rx78_cart_loader

Overview:
- Upstream stage of the RX-78 core: converts the host upload stream into write cycles for the cartridge ROMs (cart1, cart2) and the ext RAM fill area.
- After the image ends, sweeps the six VRAM planes to zero.
- Holds the Z80 in reset for the whole load, then for a fixed number of cycles after it, so the core never sees a half-loaded cartridge.

Parameters:
- CART_INDEX, 8'd1, upload_index value that selects a cartridge image.
- MAX_BYTES, 17'h9000, largest accepted image (8K cart1 + 8K cart2 + 20K ext); bytes at or above it are dropped.
- VRAM_WORDS, 14'd8192, number of addresses swept during the VRAM clear.
- HOLD_CYCLES, 16, cycles cpu_hold stays high after the clear ends.

Ports:
- clk  in  1  system clock (clk_sys domain).
- reset_n  in  1  synchronous, active-low reset.
- upload  in  1  host download active (level).
- upload_index  in  8  image type.
- upload_addr  in  25  byte address within the image.
- upload_data  in  8  byte value.
- upload_wr  in  1  one-cycle strobe: a byte is valid on upload_addr/upload_data.
- c1_we / c2_we  out  1  write strobes for the cart1 / cart2 ROM.
- c_addr  out  13  shared cart write address.
- c_data  out  8  shared cart write data.
- ext_we  out  1  ext RAM write strobe.
- ext_addr  out  15  ext RAM write address.
- ext_data  out  8  ext RAM write data.
- vclr_we  out  1  VRAM clear strobe; writes 0 to all six planes.
- vclr_addr  out  13  VRAM clear address.
- cpu_hold  out  1  active-high CPU reset request, ORed into the core reset.
- busy  out  1  high in any state other than IDLE.
- cart_size  out  2  0 = none, 1 = 8K, 2 = 16K, 3 = more than 16K.
- overflow  out  1  sticky; set when an image byte was dropped.

Behaviour:
- Reset (reset_n=0 at a clk edge), from any state:
  - state to IDLE.
  - All strobes 0, cpu_hold 0, busy 0, cart_size 0, overflow 0, counters 0.
  - A load in progress is abandoned; the partial image is not cleared.
- States: IDLE, LOAD, CLEAR, HOLD.
- IDLE -> LOAD when upload=1 and upload_index==CART_INDEX.
  - On entry, a byte-count max register is cleared and overflow is cleared.
  - cpu_hold rises in the same cycle as the transition.
- LOAD, for each cycle with upload_wr=1 (a = upload_addr):
  - a < 0x2000: c1_we pulses.
  - 0x2000 <= a < 0x4000: c2_we pulses.
  - 0x4000 <= a < MAX_BYTES: ext_we pulses with ext_addr = a - 0x4000 (15 bits).
  - a >= MAX_BYTES: no strobe; overflow set to 1.
  - Strobe, address and data are registered, so they appear exactly 1 cycle after upload_wr.
  - Only one strobe can be active per cycle.
  - The max register records the highest accepted a + 1 (17-bit, saturating at MAX_BYTES).
- LOAD -> CLEAR when upload falls.
  - A byte strobed in the same cycle that upload falls is still written.
  - cart_size is latched from the max register: 0 bytes -> 0; <= 0x2000 -> 1; <= 0x4000 -> 2; otherwise -> 3.
  - Non-contiguous images use the highest address, not the byte count.
- CLEAR:
  - vclr_we=1 every cycle; vclr_addr counts 0 .. VRAM_WORDS-1, one step per cycle.
  - Moves to HOLD after the address VRAM_WORDS-1 is written, i.e. exactly VRAM_WORDS cycles in CLEAR.
  - upload_wr is ignored in CLEAR and HOLD.
- HOLD: counts HOLD_CYCLES cycles, then moves to IDLE; cpu_hold drops on the IDLE transition.
- upload re-asserted during CLEAR or HOLD: the current sequence completes, returns to IDLE, and a new LOAD starts on the next cycle if upload is still high.
- upload with a different upload_index: ignored, state stays IDLE, no strobes.
- Counter widths: VRAM counter 14 bits, no wrap inside CLEAR; hold counter $clog2(HOLD_CYCLES+1) bits.

Decomposition:
- Shared package rx78_pkg:
  - state enum.
  - address boundary constants: CART1_END 0x2000, CART2_END 0x4000, EXT_BASE 0x4000.
  - cart_size encodings.
- No sub-module; the address decode is a small function inside the block.

Test Plan:
- 8K image: index 1, bytes at 0x0000..0x1FFF with data = addr[7:0] -> 8192 c1_we pulses, each 1 cycle after its upload_wr, no c2_we/ext_we; cart_size=1; then 8192 vclr_we cycles, 16 hold cycles, cpu_hold falls, busy=0.
- 36K image, 0x0000..0x8FFF -> c1, c2 and ext each strobed for their ranges; byte 0x4000 gives ext_addr 0, byte 0x8FFF gives ext_addr 0x4FFF; cart_size=3, overflow=0.
- Byte at 0x9000 -> no strobe, overflow=1, cart_size=3; the next load clears overflow.
- upload_index=0 with 100 strobes -> state stays IDLE, cpu_hold=0, no strobes.
- reset_n=0 at vclr_addr=0x0100 during CLEAR -> next cycle all outputs 0, IDLE; a new load runs a full 8192-cycle clear.
- Last byte 0x3FFF strobed in the same cycle upload falls -> c2_we still pulses with c_addr 0x1FFF; cart_size=2; CLEAR starts next cycle.
